// File: rtl/yonga_can_pkg.sv
// Shared CAN definitions: receiver state encoding, error codes, field
// lengths and the CRC-15 polynomial used by the packetizer and depacketizer.
package yonga_can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_RECOVER
  } state_e;

  typedef enum logic [2:0] {
    STS_NONE  = 3'b000,
    STS_STUFF = 3'b001,
    STS_CRC   = 3'b010,
    STS_FORM  = 3'b011
  } err_code_e;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  localparam int SID_LEN = 11;
  localparam int EID_LEN = 18;
  localparam int DLC_LEN = 4;
  localparam int CRC_LEN = 15;

  // One serial CRC-15 step: feedback is the incoming bit XOR the CRC MSB.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[14];
    return fb ? ({crc[13:0], 1'b0} ^ CRC_POLY) : {crc[13:0], 1'b0};
  endfunction

  // Payload length in bytes: remote frames carry none, DLC above 8 saturates.
  function automatic logic [3:0] payload_bytes(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 4'd0;
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

endpackage

// File: rtl/yonga_can_crc15.sv
// Serial CAN CRC-15 generator/checker with synchronous clear and bit enable.
module yonga_can_crc15
  import yonga_can_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [14:0] o_crc
);

  logic [14:0] crc_q;
  logic [14:0] crc_d;

  // Next CRC value: clear wins over a bit update.
  always_comb begin
    // NOTE: default assignment first so no path leaves crc_d unassigned (no latch).
    crc_d = crc_q;
    if (i_clr) begin
      crc_d = '0;
    end else if (i_en) begin
      crc_d = crc15_step(crc_q, i_bit);
    end
  end

  // CRC register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/yonga_can_depacketizer.sv
// CAN receive depacketizer: destuffs the sampled line, parses standard and
// extended frames, checks CRC/delimiters/stuffing and reports the message
// or an error code. Also flags the ACK slot for the controller.
module yonga_can_depacketizer
  import yonga_can_pkg::*;
#(
  parameter int unsigned EOF_BITS     = 7,
  parameter int unsigned RECOVER_BITS = 11
) (
  input  logic        i_depacketizer_clk,
  input  logic        i_depacketizer_rst,
  input  logic        i_depacketizer_en,
  input  logic        i_sample_pulse,
  input  logic        i_message_bit,
  output logic [10:0] o_rx_sid,
  output logic        o_rx_ide,
  output logic [17:0] o_rx_eid,
  output logic        o_rx_rtr,
  output logic [3:0]  o_rx_dlc,
  output logic [31:0] o_rx_data_reg1,
  output logic [31:0] o_rx_data_reg2,
  output logic        o_rx_valid,
  output logic        o_rx_err,
  output logic [2:0]  o_rx_err_code,
  output logic        o_rx_busy,
  output logic        o_ack_slot
);

  // Bit-counter positions inside the arbitration and control fields.
  localparam logic [5:0] ARB_RTR    = 6'(SID_LEN);                // RTR (std) or SRR (ext)
  localparam logic [5:0] ARB_IDE    = 6'(SID_LEN + 1);
  localparam logic [5:0] ARB_XRTR   = 6'(SID_LEN + 2 + EID_LEN);  // RTR of extended frame
  localparam logic [5:0] CTRL_LAST  = 6'(DLC_LEN);                // r0 at 0, DLC at 1..4
  localparam logic [5:0] CRC_LAST   = 6'(CRC_LEN - 1);
  localparam logic [5:0] EOF_LAST   = 6'(EOF_BITS - 1);
  localparam logic [5:0] RECOV_LAST = 6'(RECOVER_BITS - 1);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  stuff_cnt_q;
  logic        last_bit_q;
  logic [3:0]  byte_cnt_q;
  logic [3:0]  nbytes_q;
  logic [13:0] shift_q;

  // Shadow fields filled while the frame is parsed.
  logic [10:0] sid_sh_q;
  logic        ide_sh_q;
  logic [17:0] eid_sh_q;
  logic        rtr_sh_q;
  logic [3:0]  dlc_sh_q;
  logic [63:0] data_sh_q;

  // Registered outputs.
  logic [10:0] rx_sid_q;
  logic        rx_ide_q;
  logic [17:0] rx_eid_q;
  logic        rx_rtr_q;
  logic [3:0]  rx_dlc_q;
  logic [63:0] rx_data_q;
  logic        rx_valid_q;
  logic        rx_err_q;
  logic [2:0]  err_code_q;
  logic        ack_slot_q;

  logic        sample;
  logic        stuff_zone;
  logic        is_stuff;
  logic        crc_clr;
  logic        crc_en;
  logic [14:0] crc_val;
  logic [5:0]  byte_base;
  err_code_e   err_det;

  assign sample     = i_depacketizer_en && i_sample_pulse;
  assign stuff_zone = state_q inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  assign is_stuff   = stuff_zone && (stuff_cnt_q == 3'd5);
  assign byte_base  = {byte_cnt_q[2:0], 3'b000};

  // SOF is dominant and the CRC starts at 0, so clearing on SOF is the same
  // as shifting the SOF bit into a zeroed CRC.
  assign crc_clr = sample && (state_q == ST_IDLE) && !i_message_bit;
  assign crc_en  = sample && !is_stuff && (state_q inside {ST_ARB, ST_CTRL, ST_DATA});

  yonga_can_crc15 u_crc (
    .i_clk (i_depacketizer_clk),
    .i_rst (i_depacketizer_rst),
    .i_clr (crc_clr),
    .i_en  (crc_en),
    .i_bit (i_message_bit),
    .o_crc (crc_val)
  );

  // Error detection for the current sample; a stuff violation masks any
  // field check because a stuff bit never reaches the parser.
  always_comb begin
    err_det = STS_NONE;
    if (is_stuff) begin
      if (i_message_bit == last_bit_q) err_det = STS_STUFF;
    end else begin
      case (state_q)
        ST_CRC: begin
          if ((cnt_q == CRC_LAST) && ({shift_q, i_message_bit} != crc_val)) err_det = STS_CRC;
        end
        ST_CRC_DEL, ST_ACK_DEL, ST_EOF: begin
          if (!i_message_bit) err_det = STS_FORM;
        end
        default: ;
      endcase
    end
  end

  // Receiver FSM: destuffing, field parsing, message commit and recovery.
  always_ff @(posedge i_depacketizer_clk or posedge i_depacketizer_rst) begin
    if (i_depacketizer_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stuff_cnt_q <= '0;
      last_bit_q  <= 1'b0;
      byte_cnt_q  <= '0;
      nbytes_q    <= '0;
      shift_q     <= '0;
      sid_sh_q    <= '0;
      ide_sh_q    <= 1'b0;
      eid_sh_q    <= '0;
      rtr_sh_q    <= 1'b0;
      dlc_sh_q    <= '0;
      data_sh_q   <= '0;
      rx_sid_q    <= '0;
      rx_ide_q    <= 1'b0;
      rx_eid_q    <= '0;
      rx_rtr_q    <= 1'b0;
      rx_dlc_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      err_code_q  <= '0;
      ack_slot_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;

      if (!i_depacketizer_en) begin
        // Disable wins over a sample in the same cycle; captured fields stay.
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        ack_slot_q <= 1'b0;
      end else if (i_sample_pulse) begin
        if (err_det != STS_NONE) begin
          rx_err_q   <= 1'b1;
          err_code_q <= err_det;
          ack_slot_q <= 1'b0;
          state_q    <= ST_RECOVER;
          cnt_q      <= '0;
        end else if (is_stuff) begin
          // Legal stuff bit: dropped, starts a new run with its own value.
          stuff_cnt_q <= 3'd1;
          last_bit_q  <= i_message_bit;
        end else begin
          if (stuff_zone) begin
            stuff_cnt_q <= (i_message_bit == last_bit_q) ? stuff_cnt_q + 3'd1 : 3'd1;
            last_bit_q  <= i_message_bit;
          end

          case (state_q)
            ST_IDLE: begin
              if (!i_message_bit) begin
                state_q     <= ST_ARB;
                cnt_q       <= '0;
                stuff_cnt_q <= 3'd1;
                last_bit_q  <= 1'b0;
                shift_q     <= '0;
                sid_sh_q    <= '0;
                ide_sh_q    <= 1'b0;
                eid_sh_q    <= '0;
                rtr_sh_q    <= 1'b0;
                dlc_sh_q    <= '0;
                data_sh_q   <= '0;
              end
            end

            ST_ARB: begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q < ARB_RTR) begin
                sid_sh_q <= {sid_sh_q[9:0], i_message_bit};
              end else if (cnt_q == ARB_RTR) begin
                rtr_sh_q <= i_message_bit;   // SRR on extended frames, replaced later
              end else if (cnt_q == ARB_IDE) begin
                ide_sh_q <= i_message_bit;
                if (!i_message_bit) begin
                  state_q <= ST_CTRL;
                  cnt_q   <= '0;
                end
              end else if (cnt_q < ARB_XRTR) begin
                eid_sh_q <= {eid_sh_q[16:0], i_message_bit};
              end else if (cnt_q == ARB_XRTR) begin
                rtr_sh_q <= i_message_bit;
              end else begin
                // r1 of an extended frame.
                state_q <= ST_CTRL;
                cnt_q   <= '0;
              end
            end

            ST_CTRL: begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q != '0) dlc_sh_q <= {dlc_sh_q[2:0], i_message_bit};
              if (cnt_q == CTRL_LAST) begin
                nbytes_q   <= payload_bytes(rtr_sh_q, {dlc_sh_q[2:0], i_message_bit});
                byte_cnt_q <= '0;
                cnt_q      <= '0;
                state_q    <= (payload_bytes(rtr_sh_q, {dlc_sh_q[2:0], i_message_bit}) == 4'd0)
                              ? ST_CRC : ST_DATA;
              end
            end

            ST_DATA: begin
              shift_q <= {shift_q[12:0], i_message_bit};
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == 6'd7) begin
                data_sh_q[byte_base +: 8] <= {shift_q[6:0], i_message_bit};
                byte_cnt_q <= byte_cnt_q + 4'd1;
                cnt_q      <= '0;
                if (byte_cnt_q + 4'd1 == nbytes_q) state_q <= ST_CRC;
              end
            end

            ST_CRC: begin
              shift_q <= {shift_q[12:0], i_message_bit};
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == CRC_LAST) begin
                state_q <= ST_CRC_DEL;
                cnt_q   <= '0;
              end
            end

            ST_CRC_DEL: begin
              state_q    <= ST_ACK_SLOT;
              ack_slot_q <= 1'b1;
            end

            ST_ACK_SLOT: begin
              // Line value is whatever the acknowledger drives; not checked.
              state_q    <= ST_ACK_DEL;
              ack_slot_q <= 1'b0;
            end

            ST_ACK_DEL: begin
              state_q <= ST_EOF;
              cnt_q   <= '0;
            end

            ST_EOF: begin
              if (cnt_q == EOF_LAST) begin
                rx_sid_q   <= sid_sh_q;
                rx_ide_q   <= ide_sh_q;
                rx_eid_q   <= eid_sh_q;
                rx_rtr_q   <= rtr_sh_q;
                rx_dlc_q   <= dlc_sh_q;
                rx_data_q  <= data_sh_q;
                rx_valid_q <= 1'b1;
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end

            ST_RECOVER: begin
              if (!i_message_bit) begin
                cnt_q <= '0;
              end else if (cnt_q == RECOV_LAST) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end

            default: begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign o_rx_sid       = rx_sid_q;
  assign o_rx_ide       = rx_ide_q;
  assign o_rx_eid       = rx_eid_q;
  assign o_rx_rtr       = rx_rtr_q;
  assign o_rx_dlc       = rx_dlc_q;
  assign o_rx_data_reg1 = rx_data_q[31:0];
  assign o_rx_data_reg2 = rx_data_q[63:32];
  assign o_rx_valid     = rx_valid_q;
  assign o_rx_err       = rx_err_q;
  assign o_rx_err_code  = err_code_q;
  assign o_rx_busy      = (state_q != ST_IDLE);
  assign o_ack_slot     = ack_slot_q;

endmodule

// File: doc/yonga_can_depacketizer.md
Name: yonga_can_depacketizer

Overview:
Receive-side counterpart of the CAN packetizer. It samples the mux'd receive line on each pulse-generator sample pulse, removes stuff bits and parses standard or extended frames into ID/DLC/data fields. It checks CRC-15, delimiters and stuffing, and reports a received message or an error code to the register block. It also flags the ACK slot so the controller can drive a dominant acknowledge.

Parameters:
EOF_BITS, 7, recessive end-of-frame bits required before a message is accepted
RECOVER_BITS, 11, consecutive recessive samples needed to leave RECOVER after an error

Ports:
i_depacketizer_clk  in  1  clock
i_depacketizer_rst  in  1  reset, asynchronous, active-high
i_depacketizer_en  in  1  receiver enable; low forces IDLE synchronously
i_sample_pulse  in  1  one-cycle strobe from yonga_can_pulse_gen, bit sample point
i_message_bit  in  1  receive line (can_rx_mux); 0 = dominant
o_rx_sid  out  11  received base ID
o_rx_ide  out  1  1 = extended frame
o_rx_eid  out  18  received extended ID (0 for standard frames)
o_rx_rtr  out  1  remote request bit
o_rx_dlc  out  4  received DLC, raw value
o_rx_data_reg1  out  32  bytes 0..3; byte0 in [7:0]
o_rx_data_reg2  out  32  bytes 4..7; byte4 in [7:0]
o_rx_valid  out  1  one-cycle pulse: message accepted, outputs updated in the same cycle
o_rx_err  out  1  one-cycle pulse: frame aborted
o_rx_err_code  out  3  001 stuff, 010 crc, 011 form; holds until the next error
o_rx_busy  out  1  high in every state except IDLE
o_ack_slot  out  1  high for the whole ACK-slot bit period

Behaviour:
- Reset: all outputs 0, state IDLE, shift register, bit counter, stuff counter and CRC all 0.
- Enable: i_depacketizer_en = 0 -> IDLE next cycle. No valid/err pulse. Fields already captured are kept.
- Sampling: logic advances only on cycles where i_sample_pulse = 1.
- States: IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, RECOVER.
- IDLE: a sample of 0 is SOF.
  - Clear the CRC, load the stuff counter with 1/last=0, clear the data shadows, go to ARB.
- ARB: 11 SID bits, MSB first. Bit 12 is RTR (standard) or SRR. Bit 13 is IDE.
  - IDE = 1: 18 EID bits, MSB first, then RTR, then r1.
  - Then go to CTRL.
- CTRL: r0, then DLC[3:0], MSB first.
  - Bytes to receive = 0 if RTR = 1, else min(DLC, 8).
  - 0 bytes -> CRC; otherwise -> DATA.
- DATA: bytes MSB first. Byte n goes to shadow bits [8*(n%4)+7 : 8*(n%4)] of reg1 (n < 4) or reg2.
- Destuffing:
  - Active from SOF through the last CRC bit.
  - After 5 consecutive equal bits, the next sample is a stuff bit. It is not fed to the CRC or the parser.
  - A stuff bit equal to the previous bit -> error 001.
  - A stuff bit restarts the run count at 1 with its own value.
- CRC-15:
  - Polynomial 15'h4599, init 0.
  - Covers destuffed bits from SOF through the last data bit.
  - The 15 received CRC bits are compared after the last one; a mismatch -> error 010.
- CRC_DEL: must sample 1, else error 011.
  - o_ack_slot is set in the cycle after the CRC_DEL sample and cleared in the cycle after the ACK_SLOT sample.
  - The ACK_SLOT value is ignored.
- ACK_DEL: must sample 1, else error 011.
- EOF: EOF_BITS samples, all must be 1; a 0 -> error 011.
  - The cycle after the last EOF sample:
    - copy the shadows into the outputs;
    - pulse o_rx_valid;
    - go to IDLE.
- Any error:
  - next cycle: o_rx_err = 1 and o_rx_err_code set;
  - o_ack_slot = 0, go to RECOVER.
  - Message outputs are unchanged.
- RECOVER: count consecutive 1 samples; any 0 resets the count. At RECOVER_BITS, go to IDLE.
- Simultaneous events:
  - Reset overrides everything.
  - Disable overrides a pending sample in the same cycle.
  - A stuff error takes priority over a CRC check on the same bit.
- Widths: bit counter 6 bits, stuff counter 3 bits, byte counter 4 bits. DLC 9..15 saturates to 8 bytes, but o_rx_dlc reports the raw value.

Decomposition:
- Shared package yonga_can_pkg:
  - state encoding;
  - error codes STS_STUFF/STS_CRC/STS_FORM;
  - CRC_POLY = 15'h4599;
  - field lengths SID_LEN = 11, EID_LEN = 18, DLC_LEN = 4, CRC_LEN = 15.
- Sub-module yonga_can_crc15: serial CRC with clear, enable and bit input. It is also reused by the packetizer.

Test Plan:
- Standard frame, ID 0x123, DLC 2, data AB CD, correct CRC and stuffing -> one o_rx_valid pulse with:
  - sid = 0x123, ide = 0, rtr = 0, dlc = 2;
  - data_reg1 = 0x0000CDAB, data_reg2 = 0.
- Extended frame, SID 0x7FF, EID 0x2AAAA, DLC 8, data 01..08 -> valid with:
  - eid = 0x2AAAA;
  - data_reg1 = 0x04030201, data_reg2 = 0x08070605.
- Six consecutive dominant bits inside the SID -> err pulse with code 001. No valid pulse. Returns to IDLE only after 11 recessive samples.
- Frame from the first test with one CRC bit flipped -> code 010. o_ack_slot is never asserted. Outputs keep their previous values.
- CRC delimiter driven dominant -> code 011. A dominant EOF bit 4 -> code 011.
- Async reset asserted mid-DATA -> all outputs 0 immediately and state IDLE. A following clean RTR frame with DLC 3 -> valid with rtr = 1, dlc = 3, data regs 0.
